// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared types and constants for the instruction-fetch stage.
// Covers FSM encoding, redirect select and the branch-offset helper.
package if_stage_pkg;

   localparam int ADDR_W = 32;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      HELD    = 2'd2,
      DISCARD = 2'd3
   } fetch_state_t;

   typedef enum logic [1:0] {
      SEL_NONE   = 2'd0,
      SEL_BRANCH = 2'd1,
      SEL_JUMP   = 2'd2,
      SEL_REG    = 2'd3
   } redir_sel_t;

   // Sign-extended word offset of a 16-bit branch immediate.
   function automatic logic [ADDR_W-1:0] br_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/if_next_pc.sv
// if_next_pc: redirect target computation and priority select.
// IF_ALIGN_CHECK_EN sends misaligned jr/jalr targets to EXC_VECTOR.
module if_next_pc
   import if_stage_pkg::*;
#(
   parameter logic [ADDR_W-1:0] EXC_VECTOR = 32'h0000_0080
) (
   input  logic              i_jump,
   input  logic [25:0]       i_jump_index,
   input  logic              i_branch_taken,
   input  logic [15:0]       i_branch_imm,
   input  logic              i_pc_src,
   input  logic [ADDR_W-1:0] i_reg_target,
   input  logic [ADDR_W-1:0] i_ifid_pc_plus4,
   output logic              o_redirect,
   output logic [ADDR_W-1:0] o_target,
   output logic              o_misalign
);

   redir_sel_t        w_sel;
   logic [ADDR_W-1:0] w_jump_tgt;
   logic [ADDR_W-1:0] w_br_tgt;
   logic [ADDR_W-1:0] w_reg_tgt;

   assign w_jump_tgt = {i_ifid_pc_plus4[31:28], i_jump_index, 2'b00};
   assign w_br_tgt   = i_ifid_pc_plus4 + br_offset(i_branch_imm);

`ifdef IF_ALIGN_CHECK_EN
   assign o_misalign = i_pc_src & (|i_reg_target[1:0]);
   assign w_reg_tgt  = (|i_reg_target[1:0]) ? EXC_VECTOR : i_reg_target;
`else
   logic w_unused_align;
   assign w_unused_align = ^{EXC_VECTOR, i_reg_target[1:0]};
   assign o_misalign     = 1'b0;
   assign w_reg_tgt      = {i_reg_target[31:2], 2'b00};
`endif

   // Redirect priority: jr/jalr, then j/jal, then taken branch.
   always_comb begin
      w_sel = SEL_NONE;
      if (i_pc_src)
         w_sel = SEL_REG;
      else if (i_jump)
         w_sel = SEL_JUMP;
      else if (i_branch_taken)
         w_sel = SEL_BRANCH;
      else
         w_sel = SEL_NONE;
   end

   // Target mux driven by the selected redirect source.
   always_comb begin
      o_target = w_br_tgt;
      unique case (w_sel)
         SEL_REG:    o_target = w_reg_tgt;
         SEL_JUMP:   o_target = w_jump_tgt;
         SEL_BRANCH: o_target = w_br_tgt;
         SEL_NONE:   o_target = w_br_tgt;
         default:    o_target = w_br_tgt;
      endcase
   end

   assign o_redirect = (w_sel != SEL_NONE);

endmodule

// File: rtl/if_stage.sv
// if_stage: PC, ready/valid imem fetch FSM, hold buffer and IF/ID register.
// Optional IF_ALIGN_CHECK_EN traps misaligned jr/jalr targets (addr_exc).
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
   parameter logic [ADDR_W-1:0] EXC_VECTOR = 32'h0000_0080
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic              jump,
   input  logic [25:0]       jump_index,
   input  logic              branch_taken,
   input  logic [15:0]       branch_imm,
   input  logic              pc_src,
   input  logic [ADDR_W-1:0] reg_target,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       ifid_instr,
   output logic [ADDR_W-1:0] ifid_pc_plus4,
   output logic              ifid_valid,
   output logic              addr_exc
);

   fetch_state_t      r_state;
   fetch_state_t      w_state_nx;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_pc_nx;
   logic [ADDR_W-1:0] r_fetch_addr;
   logic [ADDR_W-1:0] w_fa_nx;
   logic [ADDR_W-1:0] r_pend;
   logic [ADDR_W-1:0] w_pend_nx;
   logic [31:0]       r_hold_instr;
   logic [31:0]       w_hold_instr_nx;
   logic [ADDR_W-1:0] r_hold_pc4;
   logic [ADDR_W-1:0] w_hold_pc4_nx;
   logic [31:0]       r_ifid_instr;
   logic [ADDR_W-1:0] r_ifid_pc4;
   logic              r_ifid_valid;

   logic              w_redir_req;
   logic              w_redir;
   logic [ADDR_W-1:0] w_target;
   logic              w_misalign;
   logic              w_done;
   logic [ADDR_W-1:0] w_fa_plus4;
   logic              w_bubble;
   logic              w_load;
   logic [31:0]       w_ld_instr;
   logic [ADDR_W-1:0] w_ld_pc4;

   if_next_pc #(
      .EXC_VECTOR(EXC_VECTOR)
   ) u_next_pc (
      .i_jump         (jump),
      .i_jump_index   (jump_index),
      .i_branch_taken (branch_taken),
      .i_branch_imm   (branch_imm),
      .i_pc_src       (pc_src),
      .i_reg_target   (reg_target),
      .i_ifid_pc_plus4(r_ifid_pc4),
      .o_redirect     (w_redir_req),
      .o_target       (w_target),
      .o_misalign     (w_misalign)
   );

   assign w_redir    = w_redir_req & ~stall;
   assign imem_req   = (r_state == FETCH) || (r_state == DISCARD);
   assign imem_addr  = r_fetch_addr;
   assign w_done     = imem_req & imem_ready;
   assign w_fa_plus4 = r_fetch_addr + 32'd4;

   // Next-state, PC and IF/ID load/bubble decisions.
   always_comb begin
      w_state_nx      = r_state;
      w_pc_nx         = r_pc;
      w_fa_nx         = r_fetch_addr;
      w_pend_nx       = r_pend;
      w_hold_instr_nx = r_hold_instr;
      w_hold_pc4_nx   = r_hold_pc4;
      w_bubble        = 1'b0;
      w_load          = 1'b0;
      w_ld_instr      = imem_rdata;
      w_ld_pc4        = w_fa_plus4;
      unique case (r_state)
         IDLE: begin
            w_state_nx = FETCH;
            if (w_redir) begin
               w_pc_nx  = w_target;
               w_fa_nx  = w_target;
               w_bubble = 1'b1;
            end else begin
               w_fa_nx = r_pc;
            end
         end
         FETCH: begin
            if (w_redir) begin
               w_bubble = 1'b1;
               if (w_done) begin
                  w_pc_nx = w_target;
                  w_fa_nx = w_target;
               end else begin
                  w_pend_nx  = w_target;
                  w_state_nx = DISCARD;
               end
            end else if (w_done && stall) begin
               w_hold_instr_nx = imem_rdata;
               w_hold_pc4_nx   = w_fa_plus4;
               w_state_nx      = HELD;
            end else if (w_done) begin
               w_load  = 1'b1;
               w_pc_nx = w_fa_plus4;
               w_fa_nx = w_fa_plus4;
            end else if (!stall) begin
               w_bubble = 1'b1;
            end
         end
         HELD: begin
            if (!stall) begin
               w_state_nx = FETCH;
               if (w_redir) begin
                  w_bubble = 1'b1;
                  w_pc_nx  = w_target;
                  w_fa_nx  = w_target;
               end else begin
                  w_load     = 1'b1;
                  w_ld_instr = r_hold_instr;
                  w_ld_pc4   = r_hold_pc4;
                  w_pc_nx    = r_hold_pc4;
                  w_fa_nx    = r_hold_pc4;
               end
            end
         end
         DISCARD: begin
            if (w_redir)
               w_pend_nx = w_target;
            if (w_done) begin
               w_state_nx = FETCH;
               w_pc_nx    = w_redir ? w_target : r_pend;
               w_fa_nx    = w_redir ? w_target : r_pend;
            end
            if (!stall)
               w_bubble = 1'b1;
         end
         default: w_state_nx = IDLE;
      endcase
   end

   // FSM, PC, fetch address and hold buffer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_pc         <= RESET_PC;
         r_fetch_addr <= RESET_PC;
         r_pend       <= RESET_PC;
         r_hold_instr <= NOP_INSTR;
         r_hold_pc4   <= '0;
      end else begin
         r_state      <= w_state_nx;
         r_pc         <= w_pc_nx;
         r_fetch_addr <= w_fa_nx;
         r_pend       <= w_pend_nx;
         r_hold_instr <= w_hold_instr_nx;
         r_hold_pc4   <= w_hold_pc4_nx;
      end
   end

   // IF/ID register: flush/redirect bubble over stall hold over load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ifid_instr <= NOP_INSTR;
         r_ifid_pc4   <= '0;
         r_ifid_valid <= 1'b0;
      end else if (flush || w_bubble) begin
         r_ifid_instr <= NOP_INSTR;
         r_ifid_valid <= 1'b0;
      end else if (w_load) begin
         r_ifid_instr <= w_ld_instr;
         r_ifid_pc4   <= w_ld_pc4;
         r_ifid_valid <= 1'b1;
      end
   end

   assign ifid_instr    = r_ifid_instr;
   assign ifid_pc_plus4 = r_ifid_pc4;
   assign ifid_valid    = r_ifid_valid;

`ifdef IF_ALIGN_CHECK_EN
   logic r_addr_exc;

   // Sticky flag for a honoured misaligned jr/jalr target.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_addr_exc <= 1'b0;
      else if (w_redir && w_misalign)
         r_addr_exc <= 1'b1;
   end

   assign addr_exc = r_addr_exc;
`else
   logic w_unused_exc;
   assign w_unused_exc = w_misalign;
   assign addr_exc     = 1'b0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed self-checking bench for if_stage.
// Memory model returns the fetch address as the instruction word.
module tb_if_stage;
   import if_stage_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        flush;
   logic        jump;
   logic [25:0] jump_index;
   logic        branch_taken;
   logic [15:0] branch_imm;
   logic        pc_src;
   logic [31:0] reg_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc_plus4;
   logic        ifid_valid;
   logic        addr_exc;

   int n_chk;
   int n_pass;

`ifdef IF_ALIGN_CHECK_EN
   localparam logic [31:0] EXP_MIS_ADDR = 32'h0000_0080;
   localparam logic [31:0] EXP_MIS_EXC  = 32'd1;
`else
   localparam logic [31:0] EXP_MIS_ADDR = 32'h0000_0400;
   localparam logic [31:0] EXP_MIS_EXC  = 32'd0;
`endif

   if_stage dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (stall),
      .flush        (flush),
      .jump         (jump),
      .jump_index   (jump_index),
      .branch_taken (branch_taken),
      .branch_imm   (branch_imm),
      .pc_src       (pc_src),
      .reg_target   (reg_target),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .imem_rdata   (imem_rdata),
      .ifid_instr   (ifid_instr),
      .ifid_pc_plus4(ifid_pc_plus4),
      .ifid_valid   (ifid_valid),
      .addr_exc     (addr_exc)
   );

   assign imem_rdata = imem_addr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk        = 0;
      n_pass       = 0;
      rst_n        = 1'b0;
      stall        = 1'b0;
      flush        = 1'b0;
      jump         = 1'b0;
      jump_index   = '0;
      branch_taken = 1'b0;
      branch_imm   = '0;
      pc_src       = 1'b0;
      reg_target   = '0;
      imem_ready   = 1'b1;

      tick();
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_valid", {31'd0, ifid_valid}, 32'd0);
      check("rst_instr", ifid_instr, 32'h0);
      check("rst_pc4", ifid_pc_plus4, 32'h0);
      check("rst_exc", {31'd0, addr_exc}, 32'd0);
      tick();
      rst_n = 1'b1;
      #1;
      check("idle_req", {31'd0, imem_req}, 32'd0);
      tick();
      check("fetch_req", {31'd0, imem_req}, 32'd1);
      check("fetch_addr0", imem_addr, 32'h0);

      tick();
      check("seq_pc4_4", ifid_pc_plus4, 32'd4);
      check("seq_v_4", {31'd0, ifid_valid}, 32'd1);
      check("seq_i_4", ifid_instr, 32'h0);
      tick();
      check("seq_pc4_8", ifid_pc_plus4, 32'd8);
      check("seq_i_8", ifid_instr, 32'h4);
      tick();
      check("seq_pc4_12", ifid_pc_plus4, 32'd12);
      check("seq_i_12", ifid_instr, 32'h8);

      pc_src     = 1'b1;
      reg_target = 32'h1000_000C;
      tick();
      pc_src = 1'b0;
      check("jr_addr", imem_addr, 32'h1000_000C);
      check("jr_bubble", {31'd0, ifid_valid}, 32'd0);
      tick();
      check("jr_pc4", ifid_pc_plus4, 32'h1000_0010);
      check("jr_valid", {31'd0, ifid_valid}, 32'd1);

      jump       = 1'b1;
      jump_index = 26'h000_0040;
      tick();
      jump = 1'b0;
      check("j_addr", imem_addr, 32'h1000_0100);
      check("j_bubble", {31'd0, ifid_valid}, 32'd0);

      pc_src     = 1'b1;
      reg_target = 32'h0000_001C;
      tick();
      pc_src = 1'b0;
      tick();
      check("pre_br_pc4", ifid_pc_plus4, 32'h0000_0020);
      branch_taken = 1'b1;
      branch_imm   = 16'hFFFE;
      tick();
      branch_taken = 1'b0;
      check("br_addr", imem_addr, 32'h0000_0018);
      check("br_bubble", {31'd0, ifid_valid}, 32'd0);
      check("br_pc4_kept", ifid_pc_plus4, 32'h0000_0020);
      tick();
      check("br_instr", ifid_instr, 32'h0000_0018);

      pc_src       = 1'b1;
      reg_target   = 32'h0000_0200;
      jump         = 1'b1;
      branch_taken = 1'b1;
      tick();
      pc_src       = 1'b0;
      jump         = 1'b0;
      branch_taken = 1'b0;
      check("prio_addr", imem_addr, 32'h0000_0200);
      tick();
      check("prio_pc4", ifid_pc_plus4, 32'h0000_0204);

      imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("wait_addr", imem_addr, 32'h0000_0204);
         check("wait_req", {31'd0, imem_req}, 32'd1);
      end
      check("wait_bubble", {31'd0, ifid_valid}, 32'd0);
      imem_ready = 1'b1;
      stall      = 1'b1;
      tick();
      check("held_req", {31'd0, imem_req}, 32'd0);
      check("held_valid", {31'd0, ifid_valid}, 32'd0);
      tick();
      stall = 1'b0;
      check("held_req2", {31'd0, imem_req}, 32'd0);
      tick();
      check("rel_valid", {31'd0, ifid_valid}, 32'd1);
      check("rel_instr", ifid_instr, 32'h0000_0204);
      check("rel_pc4", ifid_pc_plus4, 32'h0000_0208);
      tick();
      check("next_instr", ifid_instr, 32'h0000_0208);

      pc_src     = 1'b1;
      reg_target = 32'h0000_0008;
      tick();
      pc_src     = 1'b0;
      imem_ready = 1'b0;
      tick();
      check("out_addr", imem_addr, 32'h0000_0008);
      pc_src     = 1'b1;
      reg_target = 32'h0000_0400;
      tick();
      pc_src = 1'b0;
      check("disc_addr", imem_addr, 32'h0000_0008);
      check("disc_req", {31'd0, imem_req}, 32'd1);
      check("disc_valid", {31'd0, ifid_valid}, 32'd0);
      tick();
      check("disc_addr2", imem_addr, 32'h0000_0008);
      imem_ready = 1'b1;
      tick();
      check("disc_tgt", imem_addr, 32'h0000_0400);
      check("disc_drop", {31'd0, ifid_valid}, 32'd0);
      tick();
      check("disc_instr", ifid_instr, 32'h0000_0400);
      check("disc_pc4", ifid_pc_plus4, 32'h0000_0404);

      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fl_valid", {31'd0, ifid_valid}, 32'd0);
      check("fl_pc4", ifid_pc_plus4, 32'h0000_0404);
      check("fl_addr", imem_addr, 32'h0000_0408);

      pc_src     = 1'b1;
      reg_target = 32'h0000_0402;
      tick();
      pc_src = 1'b0;
      check("mis_addr", imem_addr, EXP_MIS_ADDR);
      check("mis_exc", {31'd0, addr_exc}, EXP_MIS_EXC);
      tick();
      check("mis_exc_hold", {31'd0, addr_exc}, EXP_MIS_EXC);
      check("mis_pc4", ifid_pc_plus4, EXP_MIS_ADDR + 32'd4);

      imem_ready = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      check("ar_req", {31'd0, imem_req}, 32'd0);
      check("ar_valid", {31'd0, ifid_valid}, 32'd0);
      check("ar_addr", imem_addr, 32'h0);
      check("ar_exc", {31'd0, addr_exc}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode-stage control unit.
- Owns the PC, drives a ready/valid instruction-memory port, and applies ID-resolved redirects (jump/jal, branch, jr/jalr).
- Handles load-use stalls with a one-entry hold buffer.
- Delivers instruction, PC+4 and a valid bit into decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0080, redirect target for a misaligned register target (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard hold: freeze PC and IF/ID.
- flush  in  1  force a bubble into IF/ID on the next edge.
- jump  in  1  ID instruction is j/jal.
- jump_index  in  26  instr[25:0] of the ID instruction.
- branch_taken  in  1  ID branch resolved taken.
- branch_imm  in  16  instr[15:0] of the ID branch.
- pc_src  in  1  ID instruction is jr/jalr.
- reg_target  in  32  rs value for jr/jalr.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, word aligned.
- imem_ready  in  1  memory accepts and returns data this cycle.
- imem_rdata  in  32  instruction word, valid when imem_req && imem_ready.
- ifid_instr  out  32  instruction to decode; opcode = [31:26].
- ifid_pc_plus4  out  32  PC+4 of ifid_instr.
- ifid_valid  out  1  ifid_instr is real (0 = bubble).
- addr_exc  out  1  sticky misaligned-target flag (optional feature).

Behaviour:
- Reset (async, rst_n=0), every output and register cleared or preset:
  - pc = RESET_PC; fetch_addr = RESET_PC; state = IDLE.
  - ifid_instr = 0, ifid_pc_plus4 = 0, ifid_valid = 0.
  - imem_req = 0, addr_exc = 0.
  - Reset asserted mid-transaction abandons the transaction; the memory must tolerate req dropping on reset.
- Handshake:
  - imem_addr = fetch_addr.
  - Once imem_req=1, req and addr stay stable until a cycle with imem_ready=1; that cycle completes the transaction.
- Redirect target, priority pc_src > jump > branch_taken:
  - jr/jalr: reg_target.
  - jump: {ifid_pc_plus4[31:28], jump_index, 2'b00}.
  - branch: ifid_pc_plus4 + (sign_extend(branch_imm) << 2), 32-bit wraparound.
- No delay slot: every redirect squashes the sequential fetch and bubbles IF/ID.
- Redirect is honoured only when stall=0. Decode re-presents it after the stall.
- FSM:
  - IDLE: req=0. Next cycle goes to FETCH with fetch_addr=pc. A redirect in IDLE loads pc=target and then goes to FETCH.
  - FETCH: req=1.
    - Completion with stall=0 and no redirect: IF/ID <= {rdata, fetch_addr+4, 1}; pc and fetch_addr <= fetch_addr+4; stay in FETCH.
    - Completion with stall=1: rdata and pc+4 go into the hold buffer; go to HELD; IF/ID unchanged.
    - Redirect with completion: data dropped; fetch_addr <= target; IF/ID bubble; stay in FETCH.
    - Redirect without completion: pending_target <= target; IF/ID bubble; go to DISCARD.
  - HELD: req=0. When stall drops, the buffer loads IF/ID with valid=1, fetch_addr advances, go to FETCH. A redirect in HELD, honoured only once stall=0, drops the buffer and goes to FETCH at the target.
  - DISCARD: req=1 at the old address. On completion, data is dropped, fetch_addr <= pending_target, go to FETCH. A newer redirect overwrites pending_target.
  - No completion in FETCH/DISCARD: IF/ID holds its contents when stall=1, otherwise loads a bubble.
- IF/ID update priority: reset > flush/redirect (bubble: instr=0, valid=0, pc_plus4 unchanged) > stall (hold) > load.
- Flush does not alter pc, fetch_addr or FSM state.
- Throughput: 1 instruction/cycle with zero-wait memory. Fetch-to-IF/ID latency: 1 edge after completion.

Optional Feature:
- Macro: IF_ALIGN_CHECK_EN.
- Defined:
  - A jr/jalr redirect with reg_target[1:0] != 0 redirects to EXC_VECTOR instead of the register target.
  - addr_exc sets and stays set until reset.
- Undefined:
  - reg_target[1:0] is forced to 00.
  - addr_exc is tied to 0.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE, FETCH, HELD, DISCARD.
  - NOP_INSTR = 32'h0.
  - Redirect-select enum.
  - Address width constant (32).
- One natural sub-module: if_next_pc, the combinational target computation and priority mux.

Test Plan:
- Reset release, zero-wait memory returning 0x0000_0000+addr:
  - IF/ID sees pc_plus4 = 4, 8, 12 on consecutive edges, valid=1.
  - imem_req low exactly one cycle after reset.
- jump with ifid_pc_plus4=0x1000_0010, jump_index=0x0000040:
  - Next imem_addr = 0x1000_0100.
  - Next IF/ID valid=0.
- branch_taken with branch_imm=0xFFFE, ifid_pc_plus4=0x0000_0020:
  - Target = 0x0000_0018.
- imem_ready held low 3 cycles; stall asserted on the completion cycle for 2 cycles:
  - Instruction buffered (HELD, req=0).
  - Delivered with valid=1 the cycle after stall drops; no duplicate, no loss.
- Redirect (pc_src, reg_target=0x400) while the request to 0x8 is outstanding:
  - req stays on 0x8 until ready.
  - That data is discarded, then imem_addr=0x400.
  - No valid instruction from 0x8 ever reaches IF/ID.
- With IF_ALIGN_CHECK_EN, jr to 0x402:
  - imem_addr=EXC_VECTOR and addr_exc=1, held until rst_n=0.
